// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface seq_divider_if #(
    parameter int DATAWIDTH = 32
);
    logic                 en;
    logic [DATAWIDTH-1:0] dividend;
    logic [DATAWIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [DATAWIDTH-1:0] quotient;
    logic [DATAWIDTH-1:0] remainder;
    logic                 div_by_zero;

    // Requester side: issues operands and start, observes status/results.
    modport master (
        output en, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  en, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per cycle, followed by a sign-fix stage and a registered
// output stage. Truncates toward zero; remainder takes the dividend's sign.
module seq_divider #(
    parameter int DATAWIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    seq_divider_if.slave  bus
);
    localparam int DW = DATAWIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, OUTPUT} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_out_q, rem_out_d;
    logic            dbz_q, dbz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   a_q, a_d;          // dividend as captured
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [DW-1:0]   b_mag_q, b_mag_d;
    // Partial remainder: held in DW bits between steps, widened to DW+1
    // bits for the trial compare (it is always < divisor magnitude).
    logic [DW-1:0]   prem_q, prem_d;
    logic [DW-1:0]   qsh_q, qsh_d;      // dividend magnitude shifts out, quotient bits shift in
    logic [DW-1:0]   fq_q, fq_d;        // sign-fixed results waiting for OUTPUT
    logic [DW-1:0]   fr_q, fr_d;
    logic            fz_q, fz_d;
    logic [DW:0]     trial;

    // Next-state and datapath for the IDLE/CALC/FIX/OUTPUT sequence.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_mag_d   = b_mag_q;
        prem_d    = prem_q;
        qsh_d     = qsh_q;
        fq_d      = fq_q;
        fr_d      = fr_q;
        fz_d      = fz_q;
        trial     = {prem_q, qsh_q[DW-1]};

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = CALC;
                    a_d     = bus.dividend;
                    a_neg_d = bus.dividend[DW-1];
                    b_neg_d = bus.divisor[DW-1];
                    qsh_d   = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                    b_mag_d = bus.divisor[DW-1]  ? -bus.divisor  : bus.divisor;
                    prem_d  = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (trial >= {1'b0, b_mag_q}) begin
                    prem_d = trial[DW-1:0] - b_mag_q;
                    qsh_d  = {qsh_q[DW-2:0], 1'b1};
                end else begin
                    prem_d = trial[DW-1:0];
                    qsh_d  = {qsh_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) state_d = FIX;
            end
            FIX: begin
                // Zero divisor overrides the shift-subtract result entirely.
                if (b_mag_q == '0) begin
                    fq_d = '1;
                    fr_d = a_q;
                    fz_d = 1'b1;
                end else begin
                    fq_d = (a_neg_q ^ b_neg_q) ? -qsh_q : qsh_q;
                    fr_d = a_neg_q ? -prem_q : prem_q;
                    fz_d = 1'b0;
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                quo_d     = fq_q;
                rem_out_d = fr_q;
                dbz_d     = fz_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state, with asynchronous clear of every register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_mag_q   <= '0;
            prem_q    <= '0;
            qsh_q     <= '0;
            fq_q      <= '0;
            fr_q      <= '0;
            fz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            b_mag_q   <= b_mag_d;
            prem_q    <= prem_d;
            qsh_q     <= qsh_d;
            fq_q      <= fq_d;
            fr_q      <= fr_d;
            fz_q      <= fz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at DATAWIDTH=8: directed corner cases, random
// operands against an integer-arithmetic reference, back-to-back and reset.
module tb_seq_divider;
    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic clk;
    logic rstn;
    int   tests_run = 0;
    int   fails     = 0;

    seq_divider_if #(.DATAWIDTH(W)) bus ();
    seq_divider #(.DATAWIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: C-style signed division on wide integers, wrapped to W bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = W'(ai / bi); r = W'(ai % bi); z = 1'b0;
        end
    endfunction

    // Issue one operation from IDLE, scramble inputs after capture, and
    // return results plus the number of edges from capture to done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
        bus.en = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.en = 1'b0;
        bus.dividend = W'($urandom); bus.divisor = W'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = k; break; end
        end
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; bus.en = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_release got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da [5] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'd5};
        logic [W-1:0] db [5] = '{8'd7,   8'd7,  8'hF9,  8'hFF, 8'd0};
        logic [W-1:0] eq [5] = '{8'h0E,  8'hF2, 8'hF2,  8'h80, 8'hFF};
        logic [W-1:0] er [5] = '{8'h02,  8'hFE, 8'h02,  8'h00, 8'h05};
        logic         ez [5] = '{1'b0,   1'b0,  1'b0,   1'b0,  1'b1};
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            do_op(da[i], db[i], q, r, z, lat);
            tests_run++;
            if (q !== eq[i] || r !== er[i] || z !== ez[i] || lat != LAT) begin
                fails++;
                $display("FAIL directed_%0d got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, q, r, z, lat, eq[i], er[i], ez[i], LAT);
            end
            // Results must hold after done drops.
            tests_run++;
            if (bus.done !== 1'b0 || bus.quotient !== eq[i] || bus.remainder !== er[i]) begin
                fails++;
                $display("FAIL hold_%0d got done=%b q=%h r=%h want done=0 q=%h r=%h",
                         i, bus.done, bus.quotient, bus.remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq_, er_;
        logic         z, ez_;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(a, b, eq_, er_, ez_);
            do_op(a, b, q, r, z, lat);
            tests_run++;
            if (q !== eq_ || r !== er_ || z !== ez_ || lat != LAT) begin
                fails++;
                $display("FAIL random_%0d a=%h b=%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, a, b, q, r, z, lat, eq_, er_, ez_, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int NB = 6;
        logic [W-1:0] a [NB];
        logic [W-1:0] b [NB];
        logic [W-1:0] eq_, er_;
        logic         ez_;
        int cur = 0, since = 0, last = -1;
        for (int i = 0; i < NB; i++) begin
            a[i] = W'($urandom);
            b[i] = (i == 2) ? '0 : W'($urandom);
        end
        bus.en = 1'b1; bus.dividend = a[0]; bus.divisor = b[0];
        for (int cyc = 0; cyc < NB * 11 + 20; cyc++) begin
            @(posedge clk); #1;
            since++;
            if (since == 4) begin
                bus.dividend = W'($urandom); bus.divisor = W'($urandom);
            end
            if (bus.done) begin
                model(a[cur], b[cur], eq_, er_, ez_);
                tests_run++;
                if (bus.quotient !== eq_ || bus.remainder !== er_ || bus.div_by_zero !== ez_ ||
                    bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_result_%0d got q=%h r=%h z=%b busy=%b want q=%h r=%h z=%b busy=0",
                             cur, bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, eq_, er_, ez_);
                end
                if (last >= 0) begin
                    tests_run++;
                    if (cyc - last != LAT + 1) begin
                        fails++;
                        $display("FAIL b2b_period_%0d got %0d want %0d", cur, cyc - last, LAT + 1);
                    end
                end
                last = cyc;
                cur++;
                since = 0;
                if (cur == NB) break;
                bus.dividend = a[cur]; bus.divisor = b[cur];
            end else if (last >= 0 && cyc == last + 1) begin
                tests_run++;
                if (bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_busy_gap_%0d got busy=%b want 1", cur, bus.busy);
                end
            end
        end
        bus.en = 1'b0;
        tests_run++;
        if (cur != NB) begin
            fails++;
            $display("FAIL b2b_timeout got %0d results want %0d", cur, NB);
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        bool_dummy: begin end
        bus.en = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            fails++;
            $display("FAIL midop_reset got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        lat = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk); #1;
            if (bus.done) lat++;
        end
        tests_run++;
        if (lat != 0) begin
            fails++;
            $display("FAIL midop_no_done got %0d done pulses want 0", lat);
        end
        do_op(8'd100, 8'd7, q, r, z, lat);
        tests_run++;
        if (q !== 8'h0E || r !== 8'h02 || z !== 1'b0 || lat != LAT) begin
            fails++;
            $display("FAIL midop_restart got q=%h r=%h z=%b lat=%0d want q=0e r=02 z=0 lat=%0d",
                     q, r, z, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: DATAWIDTH, default 32, operand/result width in bits (SHALL be >= 4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 en  input  1  start request; sampled only in IDLE.
REQ-005 dividend  input  DATAWIDTH  signed two's-complement numerator.
REQ-006 divisor  input  DATAWIDTH  signed two's-complement denominator.
REQ-007 busy  output  1  high while an operation is in progress (any state other than IDLE).
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 quotient  output  DATAWIDTH  signed result, registered.
REQ-010 remainder  output  DATAWIDTH  signed result, registered.
REQ-011 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-012 FSM states: IDLE, CALC, FIX, OUTPUT; IDLE->CALC on en; CALC->FIX after DATAWIDTH iterations; FIX->OUTPUT; OUTPUT->IDLE unconditionally.
REQ-013 At the edge leaving IDLE, the block SHALL capture dividend, divisor, their signs and magnitudes (unsigned DATAWIDTH bits), and clear the iteration counter; input changes after this edge SHALL be ignored.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on magnitudes (partial remainder DATAWIDTH+1 bits), producing one quotient bit MSB-first, for exactly DATAWIDTH cycles.
REQ-015 FIX SHALL apply signs: quotient negated iff dividend and divisor signs differ; remainder negated iff dividend negative (truncation toward zero; remainder sign follows dividend).
REQ-016 OUTPUT SHALL register quotient, remainder, div_by_zero and drive done=1; done SHALL return to 0 on the next edge.
REQ-017 Latency: done high for the single cycle following the (DATAWIDTH+2)th edge after the capture edge; throughput one operation per DATAWIDTH+3 cycles.
REQ-018 en held high continuously SHALL start a new operation on the edge where done clears; en in CALC/FIX/OUTPUT SHALL have no effect.
REQ-019 quotient/remainder/div_by_zero SHALL hold their values until the next OUTPUT state.
REQ-020 Divisor zero: quotient = all ones, remainder = dividend unmodified, div_by_zero = 1, same latency as normal operation.
REQ-021 Overflow (dividend = most negative, divisor = -1): quotient = most negative value (wrap), remainder = 0, div_by_zero = 0.
REQ-022 All arithmetic SHALL be modulo 2^DATAWIDTH on results; no saturation.

Reset
REQ-023 rstn low SHALL asynchronously force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; first en after rstn release SHALL start a fresh operation with normal latency.

Verification (DATAWIDTH=8)
REQ-025 dividend=100, divisor=7, en one cycle -> done after 10 edges, quotient=0x0E, remainder=0x02, div_by_zero=0.
REQ-026 dividend=-100 (0x9C), divisor=7 -> quotient=0xF2 (-14), remainder=0xFE (-2); dividend=100, divisor=-7 -> quotient=0xF2, remainder=0x02.
REQ-027 dividend=0x80, divisor=0xFF -> quotient=0x80, remainder=0x00, div_by_zero=0.
REQ-028 dividend=5, divisor=0 -> quotient=0xFF, remainder=0x05, div_by_zero=1, done at normal latency.
REQ-029 en held high, operand pairs changed each done -> back-to-back results every 11 cycles, busy low exactly one cycle between operations, inputs changed mid-CALC have no effect.
REQ-030 rstn pulsed low during CALC -> all outputs 0 immediately, no done; subsequent 100/7 gives REQ-025 result.
